// File: rtl/cd_drive_comm.sv
// cd_drive_comm: serial packet exchange with a host CD block.
// The host clocks COMCLK. Each byte is requested with COMREQ_N, and
// COMSYNC_N marks the first byte of a packet. Status bytes go out on
// CDATA and command bytes come in on HDATA, both LSB-first.
module cd_drive_comm #(
    parameter int PKT_LEN = 13,
    parameter int CMD_LEN = 11,
    parameter int GAP_LEN = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 CE,
    input  logic                 COMCLK,
    input  logic                 HDATA,
    output logic                 CDATA,
    output logic                 COMREQ_N,
    output logic                 COMSYNC_N,
    input  logic                 START,
    input  logic [8*PKT_LEN-1:0] STAT_IN,
    output logic [8*CMD_LEN-1:0] CMD_OUT,
    output logic                 CMD_VALID,
    output logic                 ERR,
    output logic                 BUSY
);

    localparam int BW = $clog2(PKT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN + 1) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        SHIFT = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                 state_q;
    logic                   comclk_q;
    logic [8*PKT_LEN-1:0]   stat_q;     // status bytes still to send; the current byte sits in [7:0]
    logic [8*CMD_LEN-1:0]   cmd_q;
    logic [7:0]             rx_q;
    logic [2:0]             bit_cnt_q;
    logic [BW-1:0]          byte_cnt_q;
    logic [TW-1:0]          to_cnt_q;
    logic [GW-1:0]          gap_cnt_q;
    logic                   cdata_q;
    logic                   comreq_n_q;
    logic                   comsync_n_q;
    logic                   cmd_valid_q;
    logic                   err_q;

    logic                   rise;
    logic                   fall;
    logic [7:0]             tx_byte;
    logic [7:0]             rx_byte;
    logic [BW-1:0]          byte_next;

    // COMCLK edge detection against the CE-gated copy, plus the next byte and count values
    always_comb begin
        rise      = COMCLK & ~comclk_q;
        fall      = ~COMCLK & comclk_q;
        tx_byte   = stat_q[7:0];
        rx_byte   = {HDATA, rx_q[7:1]};
        byte_next = byte_cnt_q + 1'b1;
    end

    // Packet FSM, together with its counters and all registered outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            comclk_q    <= 1'b1;
            stat_q      <= '0;
            cmd_q       <= '0;
            rx_q        <= '0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            to_cnt_q    <= '0;
            gap_cnt_q   <= '0;
            cdata_q     <= 1'b1;
            comreq_n_q  <= 1'b1;
            comsync_n_q <= 1'b1;
            cmd_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else if (CE) begin
            comclk_q    <= COMCLK;
            cmd_valid_q <= 1'b0;
            err_q       <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (START) begin
                        stat_q      <= STAT_IN;
                        byte_cnt_q  <= '0;
                        bit_cnt_q   <= '0;
                        to_cnt_q    <= '0;
                        cdata_q     <= STAT_IN[0];
                        comreq_n_q  <= 1'b0;
                        comsync_n_q <= 1'b0;
                        state_q     <= REQ;
                    end
                end
                REQ, SHIFT: begin
                    if (rise || fall) begin
                        to_cnt_q <= '0;
                    end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                        // The host went silent in the middle of a byte, so drop the packet
                        to_cnt_q    <= '0;
                        err_q       <= 1'b1;
                        comreq_n_q  <= 1'b1;
                        comsync_n_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                    // A fall presents the bit selected by the number of rises seen so far
                    if (fall) begin
                        cdata_q <= tx_byte[bit_cnt_q];
                        state_q <= SHIFT;
                    end
                    // Rises are only meaningful once the first fall has started the byte
                    if (rise && (state_q == SHIFT)) begin
                        rx_q      <= rx_byte;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            for (int i = 0; i < CMD_LEN; i++) begin
                                if (byte_cnt_q == BW'(i)) begin
                                    cmd_q[8*i +: 8] <= rx_byte;
                                end
                            end
                            comreq_n_q <= 1'b1;
                            if (byte_cnt_q == '0) begin
                                comsync_n_q <= 1'b1;
                            end
                            byte_cnt_q <= byte_next;
                            stat_q     <= stat_q >> 8;
                            gap_cnt_q  <= '0;
                            state_q    <= (byte_next < BW'(PKT_LEN)) ? GAP : DONE;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_q == GW'(GAP_LEN - 1)) begin
                        bit_cnt_q  <= '0;
                        to_cnt_q   <= '0;
                        cdata_q    <= tx_byte[0];
                        comreq_n_q <= 1'b0;
                        state_q    <= REQ;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    cmd_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output ports come straight from the registers
    assign CDATA     = cdata_q;
    assign COMREQ_N  = comreq_n_q;
    assign COMSYNC_N = comsync_n_q;
    assign CMD_OUT   = cmd_q;
    assign CMD_VALID = cmd_valid_q;
    assign ERR       = err_q;
    assign BUSY      = (state_q != IDLE);

endmodule

// File: doc/cd_drive_comm.md
CD_DRIVE_COMM -- requirements
Module: cd_drive_comm

Interface
REQ-001 The module SHALL have parameter PKT_LEN, default 13, meaning the number of bytes per packet exchange.
REQ-002 The module SHALL have parameter CMD_LEN, default 11, meaning the number of leading received bytes kept as the command (CMD_LEN <= PKT_LEN).
REQ-003 The module SHALL have parameter GAP_LEN, default 4, meaning the number of CE cycles COMREQ_N stays high between bytes.
REQ-004 The module SHALL have parameter TIMEOUT, default 1024, meaning the number of CE cycles without a COMCLK edge before a byte is aborted.
REQ-005 Port CLK, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-006 Port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port CE, input, 1 bit: clock enable; state, counters and edge detection SHALL advance only when CE=1.
REQ-008 Port COMCLK, input, 1 bit: serial clock from the host CD block; idles high.
REQ-009 Port HDATA, input, 1 bit: serial data from the host.
REQ-010 Port CDATA, output, 1 bit: serial data to the host.
REQ-011 Port COMREQ_N, output, 1 bit: active-low byte request to the host.
REQ-012 Port COMSYNC_N, output, 1 bit: active-low packet-start marker.
REQ-013 Port START, input, 1 bit: one-cycle request to begin a packet exchange.
REQ-014 Port STAT_IN, input, 8*PKT_LEN bits: status packet to send; byte 0 is in bits [7:0].
REQ-015 Port CMD_OUT, output, 8*CMD_LEN bits: received command; byte 0 is in bits [7:0].
REQ-016 Port CMD_VALID, output, 1 bit: one-CE-cycle pulse when a full packet completes.
REQ-017 Port ERR, output, 1 bit: one-CE-cycle pulse on a timeout abort.
REQ-018 Port BUSY, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-019 The FSM SHALL use the states IDLE, REQ, SHIFT, GAP and DONE.
REQ-020 COMCLK edges SHALL be detected against a registered copy of COMCLK that updates when CE=1; a low-to-high change is a rise, a high-to-low change is a fall.
REQ-021 In IDLE with START=1 and CE=1: STAT_IN SHALL be latched, the byte counter cleared, COMSYNC_N driven low, and the state set to REQ.
REQ-022 START SHALL be ignored when the state is not IDLE.
REQ-023 On entry to REQ, CDATA SHALL present bit 0 of the current byte and COMREQ_N SHALL go low.
REQ-024 COMREQ_N SHALL stay low throughout REQ and SHIFT.
REQ-025 On the first COMCLK fall, REQ SHALL transition to SHIFT; each COMCLK fall SHALL leave CDATA holding the current bit, with no advance before the first rise.
REQ-026 On each COMCLK rise, HDATA SHALL be sampled into the receive shift register LSB-first, and CDATA SHALL advance to the next bit after the following fall.
REQ-027 A 3-bit bit counter SHALL count the sampled rises; on the 8th rise the byte is complete.
REQ-028 On byte complete: the received byte SHALL be stored at index byte_cnt if byte_cnt < CMD_LEN (discarded otherwise), COMREQ_N SHALL go high, COMSYNC_N SHALL go high after byte 0, and byte_cnt SHALL increment.
REQ-029 After a byte completes, the state SHALL go to GAP if byte_cnt < PKT_LEN, else to DONE.
REQ-030 GAP SHALL hold COMREQ_N high for exactly GAP_LEN CE cycles, then enter REQ; COMCLK edges during GAP SHALL be ignored.
REQ-031 DONE SHALL pulse CMD_VALID for one CE cycle, with CMD_OUT already updated, then return to IDLE.
REQ-032 CMD_OUT SHALL change only on byte storage and SHALL hold its value otherwise.
REQ-033 A timeout counter SHALL reset on entry to REQ and on any COMCLK edge; reaching TIMEOUT in REQ or SHIFT SHALL pulse ERR, set COMREQ_N and COMSYNC_N high, and return to IDLE without a CMD_VALID pulse.
REQ-034 A simultaneous rise and byte-complete in the same cycle as CE=0 SHALL have no effect, since all state is CE-gated.

Reset
REQ-035 While RST_N=0, the outputs SHALL be: state=IDLE, CDATA=1, COMREQ_N=1, COMSYNC_N=1, CMD_OUT=0, CMD_VALID=0, ERR=0, BUSY=0, and all counters 0.
REQ-036 Reset asserted mid-packet SHALL abort immediately with no CMD_VALID pulse; after release the module SHALL wait for a new START.

Verification
REQ-037 Bench shall run a full packet: STAT_IN bytes 0x00..0x0C, host sends bytes 0xA0..0xAC with 8 clocks per byte -> host receives 0x00..0x0C LSB-first, CMD_OUT bytes = 0xA0..0xAA, one CMD_VALID pulse.
REQ-038 Bench shall check the framing: COMSYNC_N is low only during byte 0, and COMREQ_N is high for exactly 4 CE cycles between bytes.
REQ-039 Bench shall test a timeout: the host stops after 3 bits of byte 5 -> ERR pulses TIMEOUT cycles after the last edge, BUSY=0, CMD_OUT retains its prior value.
REQ-040 Bench shall test reset mid-packet: RST_N low during byte 2 -> all outputs are immediately at reset values; a subsequent START runs a clean packet.
REQ-041 Bench shall test START while BUSY=1: START pulsed during byte 4 -> no effect, and the packet completes normally.
REQ-042 Bench shall test CE gating: CE toggling 1-of-3 cycles with a slow COMCLK -> results identical to REQ-037.
